// File: rtl/sd_sb_portmux_if.sv
// Client-side request/response bundle and scoreboard-side channels for sd_sb_portmux.
// slave is the mux view, master is the surrounding-logic view.
interface sd_sb_portmux_if #(
  parameter int clients = 4,
  parameter int width   = 32,
  parameter int asz     = 5,
  parameter int txid_sz = 2
);
  logic [clients-1:0]       c_srdy;
  logic [clients-1:0]       c_drdy;
  logic [clients-1:0]       c_req_type;
  logic [clients*width-1:0] c_mask;
  logic [clients*width-1:0] c_data;
  logic [clients*asz-1:0]   c_itemid;

  logic                     p_srdy;
  logic                     p_drdy;
  logic                     p_req_type;
  logic [txid_sz-1:0]       p_txid;
  logic [width-1:0]         p_mask;
  logic [width-1:0]         p_data;
  logic [asz-1:0]           p_itemid;

  logic                     r_srdy;
  logic                     r_drdy;
  logic [txid_sz-1:0]       r_txid;
  logic [width-1:0]         r_data;

  logic [clients-1:0]       rc_srdy;
  logic [clients-1:0]       rc_drdy;
  logic [width-1:0]         rc_data;

  modport slave (
    input  c_srdy, c_req_type, c_mask, c_data, c_itemid,
    output c_drdy,
    output p_srdy, p_req_type, p_txid, p_mask, p_data, p_itemid,
    input  p_drdy,
    input  r_srdy, r_txid, r_data,
    output r_drdy,
    output rc_srdy, rc_data,
    input  rc_drdy
  );

  modport master (
    output c_srdy, c_req_type, c_mask, c_data, c_itemid,
    input  c_drdy,
    input  p_srdy, p_req_type, p_txid, p_mask, p_data, p_itemid,
    output p_drdy,
    output r_srdy, r_txid, r_data,
    input  r_drdy,
    input  rc_srdy, rc_data,
    output rc_drdy
  );
endinterface

// File: rtl/sd_sb_portmux.sv
// Round-robin multi-client front end for sd_scoreboard with
// per-client outstanding-read limits and txid response demux.
module sd_sb_portmux #(
  parameter int clients   = 4,
  parameter int width     = 32,
  parameter int items     = 32,
  parameter int asz       = $clog2(items),
  parameter int txid_sz   = $clog2(clients),
  parameter int max_outst = 4
) (
  input logic clk,
  input logic reset,
  sd_sb_portmux_if.slave bus
);

  localparam int CW = $clog2(clients);
  localparam int OW = 4;

  logic [CW-1:0]      ptr_q, ptr_d;
  logic [OW-1:0]      outst_q [clients];
  logic [OW-1:0]      outst_d [clients];
  logic               p_srdy_q, p_srdy_d;
  logic               p_type_q, p_type_d;
  logic [txid_sz-1:0] p_txid_q, p_txid_d;
  logic [width-1:0]   p_mask_q, p_mask_d;
  logic [width-1:0]   p_data_q, p_data_d;
  logic [asz-1:0]     p_item_q, p_item_d;

  logic [clients-1:0] elig;
  logic               free;
  logic               found;
  logic               gnt_v;
  logic [CW-1:0]      gnt;
  logic [CW:0]        idx;
  logic               rt_ok;
  logic               r_sel;
  logic               r_fire;
  logic               inc;
  logic               dec;

  assign free  = ~p_srdy_q | bus.p_drdy;
  assign gnt_v = free & found & ~reset;
  assign rt_ok = {1'b0, bus.r_txid} < (txid_sz+1)'(clients);

  // Rotating search: first eligible client at or after ptr_q.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < clients; k++) begin
      elig[k] = bus.c_srdy[k] &
        (bus.c_req_type[k] | (outst_q[k] < OW'(max_outst)));
    end
    for (int i = 0; i < clients; i++) begin
      idx = {1'b0, ptr_q} + (CW+1)'(i);
      if (idx >= (CW+1)'(clients))
        idx = idx - (CW+1)'(clients);
      if (!found && elig[idx[CW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    bus.c_drdy = '0;
    if (gnt_v)
      bus.c_drdy = clients'(1) << gnt;
  end

  always_comb begin
    bus.rc_srdy = '0;
    r_sel       = 1'b0;
    for (int j = 0; j < clients; j++) begin
      bus.rc_srdy[j] = bus.r_srdy & rt_ok &
        (bus.r_txid == txid_sz'(j));
      r_sel = r_sel |
        (bus.rc_drdy[j] & (bus.r_txid == txid_sz'(j)));
    end
    // Out-of-range txids are swallowed so they never stall the scoreboard.
    bus.r_drdy  = ~rt_ok | r_sel;
    bus.rc_data = bus.r_data;
    r_fire      = bus.r_srdy & bus.r_drdy & rt_ok;
  end

  always_comb begin
    p_srdy_d = p_srdy_q;
    p_type_d = p_type_q;
    p_txid_d = p_txid_q;
    p_mask_d = p_mask_q;
    p_data_d = p_data_q;
    p_item_d = p_item_q;
    ptr_d    = ptr_q;
    if (free) begin
      p_srdy_d = found;
      if (found) begin
        p_type_d = bus.c_req_type[gnt];
        p_txid_d = txid_sz'(gnt);
        p_mask_d = bus.c_mask[gnt*width +: width];
        p_data_d = bus.c_data[gnt*width +: width];
        p_item_d = bus.c_itemid[gnt*asz +: asz];
        ptr_d    = (gnt == CW'(clients-1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    for (int k = 0; k < clients; k++) begin
      inc = gnt_v & ~bus.c_req_type[gnt] & (gnt == CW'(k));
      dec = r_fire & (bus.r_txid == txid_sz'(k));
      outst_d[k] = outst_q[k];
      unique case (1'b1)
        (inc & ~dec):
          outst_d[k] = outst_q[k] + 1'b1;
        (dec & ~inc & (outst_q[k] != '0)):
          outst_d[k] = outst_q[k] - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      p_srdy_q <= 1'b0;
      p_type_q <= 1'b0;
      p_txid_q <= '0;
      p_mask_q <= '0;
      p_data_q <= '0;
      p_item_q <= '0;
      for (int k = 0; k < clients; k++)
        outst_q[k] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      p_srdy_q <= p_srdy_d;
      p_type_q <= p_type_d;
      p_txid_q <= p_txid_d;
      p_mask_q <= p_mask_d;
      p_data_q <= p_data_d;
      p_item_q <= p_item_d;
      for (int k = 0; k < clients; k++)
        outst_q[k] <= outst_d[k];
    end
  end

  assign bus.p_srdy     = p_srdy_q;
  assign bus.p_req_type = p_type_q;
  assign bus.p_txid     = p_txid_q;
  assign bus.p_mask     = p_mask_q;
  assign bus.p_data     = p_data_q;
  assign bus.p_itemid   = p_item_q;

endmodule
